scl_expander: RTL and testbench

SCL_EXPANDER -- requirements
Module: scl_expander

---
 rtl/scl_expander.sv | 151 +++++++++++++++
 tb/tb_scl_expander.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/scl_expander.sv
// 2x horizontal pixel expander: each input pixel becomes a MID/CUR output pair.
// Define SCL_EXPANDER_INTERP_EN to make MID the rounded average of prev and cur.
module scl_expander #(
  parameter int FIFO_AW = 2
) (
  input  logic       tm3_clk_v0,
  input  logic       reset,
  input  logic       vidin_new_data_scld_2,
  input  logic [7:0] vidin_gray_scld_2,
  input  logic       vidin_sol_scld_2,
  output logic       vidout_new_data,
  output logic [7:0] vidout_gray,
  output logic       vidout_sol,
  output logic       vidout_overflow,
  output logic       vidout_busy
);

  localparam int DEPTH = 2 ** FIFO_AW;
  localparam logic [FIFO_AW:0]   FULL_CNT = (FIFO_AW+1)'(DEPTH);
  localparam logic [FIFO_AW:0]   CNT_ONE  = 1;
  localparam logic [FIFO_AW-1:0] PTR_ONE  = 1;

  typedef enum logic [1:0] {
    IDLE,
    EMIT_MID,
    EMIT_CUR
  } state_t;

  state_t state_q, state_d;

  logic [8:0]         mem_q [DEPTH];
  logic [FIFO_AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [FIFO_AW:0]   cnt_q, cnt_d;

  logic [7:0] cur_q, cur_d;
  logic [7:0] prev_q, prev_d;
  logic       pv_q, pv_d;

  logic       nd_q, nd_d;
  logic [7:0] gray_q, gray_d;
  logic       sol_q, sol_d;
  logic       ovf_q;

  logic       empty, full, pop, push, drop;
  logic [7:0] head_gray;
  logic       head_sol;
  logic [7:0] mid;

  assign empty     = (cnt_q == '0);
  assign full      = (cnt_q == FULL_CNT);
  assign head_sol  = mem_q[rd_ptr_q][8];
  assign head_gray = mem_q[rd_ptr_q][7:0];

  // A pop happens only on the cycle that launches a new MID.
  assign pop  = !empty && (state_q == IDLE || state_q == EMIT_CUR);
  assign push = vidin_new_data_scld_2 && (!full || pop);
  assign drop = vidin_new_data_scld_2 && full && !pop;

`ifdef SCL_EXPANDER_INTERP_EN
  logic [8:0] sum;
  assign sum = {1'b0, prev_q} + {1'b0, head_gray} + 9'd1;
  assign mid = (head_sol || !pv_q) ? head_gray : sum[8:1];
`else
  logic unused_prev;
  assign unused_prev = ^{prev_q, pv_q};
  assign mid = head_gray;
`endif

  always_comb begin
    cnt_d = cnt_q;
    if (push && !pop)
      cnt_d = cnt_q + CNT_ONE;
    else if (pop && !push)
      cnt_d = cnt_q - CNT_ONE;
  end

  always_comb begin
    state_d = state_q;
    nd_d    = 1'b0;
    gray_d  = gray_q;
    sol_d   = sol_q;
    cur_d   = cur_q;
    prev_d  = prev_q;
    pv_d    = pv_q;
    unique case (state_q)
      IDLE, EMIT_CUR: begin
        if (!empty) begin
          cur_d   = head_gray;
          gray_d  = mid;
          sol_d   = head_sol;
          nd_d    = 1'b1;
          state_d = EMIT_MID;
        end else begin
          state_d = IDLE;
        end
      end
      EMIT_MID: begin
        gray_d  = cur_q;
        sol_d   = 1'b0;
        nd_d    = 1'b1;
        prev_d  = cur_q;
        pv_d    = 1'b1;
        state_d = EMIT_CUR;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge tm3_clk_v0) begin
    if (push)
      mem_q[wr_ptr_q] <= {vidin_sol_scld_2, vidin_gray_scld_2};
  end

  always_ff @(posedge tm3_clk_v0) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      state_q  <= IDLE;
      cur_q    <= '0;
      prev_q   <= '0;
      pv_q     <= 1'b0;
      nd_q     <= 1'b0;
      gray_q   <= '0;
      sol_q    <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      if (push)
        wr_ptr_q <= wr_ptr_q + PTR_ONE;
      if (pop)
        rd_ptr_q <= rd_ptr_q + PTR_ONE;
      cnt_q   <= cnt_d;
      state_q <= state_d;
      cur_q   <= cur_d;
      prev_q  <= prev_d;
      pv_q    <= pv_d;
      nd_q    <= nd_d;
      gray_q  <= gray_d;
      sol_q   <= sol_d;
      if (drop)
        ovf_q <= 1'b1;
    end
  end

  assign vidout_new_data = nd_q;
  assign vidout_gray     = gray_q;
  assign vidout_sol      = sol_q;
  assign vidout_overflow = ovf_q;
  assign vidout_busy     = !empty || (state_q != IDLE);

endmodule

// File: tb/tb_scl_expander.sv
// Directed bench for scl_expander: latency, doubling, line breaks,
// FIFO overflow and reset during a pending pair.
module tb_scl_expander;

  logic       clk = 1'b0;
  logic       rst;
  logic       stb;
  logic [7:0] gray;
  logic       sol;
  logic       nd;
  logic [7:0] ogray;
  logic       osol;
  logic       ovf;
  logic       busy;

  int nvec = 0;
  int nerr = 0;
  int cyc  = 0;

  logic [7:0] qg[$];
  logic       qs[$];
  int         qc[$];

  scl_expander #(.FIFO_AW(2)) dut (
    .tm3_clk_v0           (clk),
    .reset                (rst),
    .vidin_new_data_scld_2(stb),
    .vidin_gray_scld_2    (gray),
    .vidin_sol_scld_2     (sol),
    .vidout_new_data      (nd),
    .vidout_gray          (ogray),
    .vidout_sol           (osol),
    .vidout_overflow      (ovf),
    .vidout_busy          (busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (nd === 1'b1) begin
      qg.push_back(ogray);
      qs.push_back(osol);
      qc.push_back(cyc);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) tick();
  endtask

  task automatic push_px(input logic s, input logic [7:0] g);
    stb  = 1'b1;
    sol  = s;
    gray = g;
    tick();
    stb  = 1'b0;
  endtask

  task automatic clearq();
    qg.delete();
    qs.delete();
    qc.delete();
  endtask

  task automatic test_reset();
    rst  = 1'b1;
    stb  = 1'b1;
    sol  = 1'b1;
    gray = 8'hAA;
    idle(2);
    rst = 1'b0;
    stb = 1'b0;
    clearq();
    @(negedge clk);
    nvec++;
    if ({nd, ogray, osol, ovf, busy} !== 12'h000) begin
      nerr++;
      $display("FAIL reset_outs got nd=%b g=%h s=%b o=%b b=%b want all 0",
               nd, ogray, osol, ovf, busy);
    end
    idle(5);
    nvec++;
    if (qg.size() != 0) begin
      nerr++;
      $display("FAIL reset_discard got %0d strobes want 0", qg.size());
    end
  endtask

  task automatic test_single();
    int s;
    clearq();
    s = cyc;
    push_px(1'b1, 8'h40);
    idle(2);
    @(negedge clk);
    nvec++;
    if (busy !== 1'b1) begin
      nerr++;
      $display("FAIL single_busy_n3 got %b want 1", busy);
    end
    tick();
    @(negedge clk);
    nvec++;
    if (busy !== 1'b0) begin
      nerr++;
      $display("FAIL single_busy_n4 got %b want 0", busy);
    end
    idle(3);
    nvec++;
    if (qg.size() != 2) begin
      nerr++;
      $display("FAIL single_count got %0d want 2", qg.size());
    end else begin
      nvec++;
      if (qg[0] !== 8'h40 || qs[0] !== 1'b1 || qc[0] != s + 2) begin
        nerr++;
        $display("FAIL single_mid got %h/%b@%0d want 40/1@%0d",
                 qg[0], qs[0], qc[0] - s, 2);
      end
      nvec++;
      if (qg[1] !== 8'h40 || qs[1] !== 1'b0 || qc[1] != s + 3) begin
        nerr++;
        $display("FAIL single_cur got %h/%b@%0d want 40/0@%0d",
                 qg[1], qs[1], qc[1] - s, 3);
      end
    end
  endtask

  task automatic check_four(input string nm, input int s,
                            input logic [31:0] eg, input logic [3:0] es);
    nvec++;
    if (qg.size() != 4) begin
      nerr++;
      $display("FAIL %s_count got %0d want 4", nm, qg.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        nvec++;
        if (qg[i] !== eg[31-8*i -: 8] || qs[i] !== es[3-i] ||
            qc[i] != s + 2 + i) begin
          nerr++;
          $display("FAIL %s_px%0d got %h/%b@%0d want %h/%b@%0d", nm, i,
                   qg[i], qs[i], qc[i] - s, eg[31-8*i -: 8], es[3-i], 2 + i);
        end
      end
    end
  endtask

  task automatic test_same_line();
    int s;
    clearq();
    s = cyc;
    push_px(1'b1, 8'h10);
    idle(1);
    push_px(1'b0, 8'h21);
    idle(6);
`ifdef SCL_EXPANDER_INTERP_EN
    check_four("same_line", s, 32'h10101921, 4'b1000);
`else
    check_four("same_line", s, 32'h10102121, 4'b1000);
`endif
  endtask

  task automatic test_line_break();
    int s;
    clearq();
    s = cyc;
    push_px(1'b1, 8'hF0);
    idle(1);
    push_px(1'b1, 8'h00);
    idle(6);
    check_four("line_break", s, 32'hF0F00000, 4'b1010);
  endtask

  task automatic test_overflow();
    logic [7:0] exp_g[$];
    logic [7:0] acc[$];
    logic [7:0] m;
    clearq();
    for (int i = 1; i <= 10; i++) begin
      stb  = 1'b1;
      sol  = (i == 1);
      gray = 8'(i);
      tick();
    end
    stb = 1'b0;
    idle(30);
    nvec++;
    if (ovf !== 1'b1) begin
      nerr++;
      $display("FAIL ovf_flag got %b want 1", ovf);
    end
    nvec++;
    if (busy !== 1'b0) begin
      nerr++;
      $display("FAIL ovf_busy got %b want 0", busy);
    end
    for (int i = 1; i <= 8; i++) acc.push_back(8'(i));
    acc.push_back(8'd10);
    for (int i = 0; i < acc.size(); i++) begin
      m = acc[i];
`ifdef SCL_EXPANDER_INTERP_EN
      if (i > 0) m = 8'((9'(acc[i-1]) + 9'(acc[i]) + 9'd1) >> 1);
`endif
      exp_g.push_back(m);
      exp_g.push_back(acc[i]);
    end
    nvec++;
    if (qg.size() != exp_g.size()) begin
      nerr++;
      $display("FAIL ovf_count got %0d want %0d", qg.size(), exp_g.size());
    end else begin
      for (int i = 0; i < exp_g.size(); i++) begin
        nvec++;
        if (qg[i] !== exp_g[i] || qs[i] !== (i == 0) || qc[i] != qc[0] + i) begin
          nerr++;
          $display("FAIL ovf_px%0d got %h/%b@+%0d want %h/%b@+%0d", i,
                   qg[i], qs[i], qc[i] - qc[0], exp_g[i], (i == 0), i);
        end
      end
    end
  endtask

  task automatic test_reset_midpair();
    clearq();
    push_px(1'b0, 8'h55);
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    @(negedge clk);
    nvec++;
    if ({nd, ogray, osol, ovf, busy} !== 12'h000) begin
      nerr++;
      $display("FAIL midpair_outs got nd=%b g=%h s=%b o=%b b=%b want all 0",
               nd, ogray, osol, ovf, busy);
    end
    idle(4);
    nvec++;
    if (qg.size() != 1) begin
      nerr++;
      $display("FAIL midpair_count got %0d want 1 (no CUR)", qg.size());
    end
    clearq();
    push_px(1'b0, 8'h80);
    idle(6);
    nvec++;
    if (qg.size() != 2) begin
      nerr++;
      $display("FAIL post_rst_count got %0d want 2", qg.size());
    end else begin
      nvec++;
      if (qg[0] !== 8'h80 || qg[1] !== 8'h80 || qs[0] !== 1'b0) begin
        nerr++;
        $display("FAIL post_rst_px got %h,%h s=%b want 80,80 s=0",
                 qg[0], qg[1], qs[0]);
      end
    end
  endtask

  initial begin
    rst  = 1'b1;
    stb  = 1'b0;
    sol  = 1'b0;
    gray = 8'h00;
    test_reset();
    test_single();
    test_same_line();
    test_line_break();
    test_overflow();
    test_reset_midpair();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

endmodule
